// File: rtl/ms_latch_seq.sv
// Master/slave latch-bank sequencer: non-overlapping enables with a dead gap,
// held data word, and a one-cycle ack once the slave stage holds the word.
module ms_latch_seq #(
    parameter int WIDTH = 8,
    parameter int HOLD  = 2,
    parameter int DEAD  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             clr,
    input  logic [WIDTH-1:0] d_in,
    output logic [WIDTH-1:0] lat_d,
    output logic             m_en,
    output logic             s_en,
    output logic             busy,
    output logic             ack
);

    localparam int MAXC = (HOLD > DEAD) ? HOLD : DEAD;
    localparam int CW   = $clog2(MAXC + 1);

    localparam logic [CW-1:0] HOLD_T = CW'(HOLD - 1);
    localparam logic [CW-1:0] DEAD_T = CW'(DEAD - 1);

    typedef enum logic [2:0] {
        IDLE,
        MASTER,
        GAP,
        SLAVE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] lat_d_q, lat_d_d;
    logic             m_en_q, m_en_d;
    logic             s_en_q, s_en_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        lat_d_d = lat_d_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (req | clr) begin
                    state_d = MASTER;
                    lat_d_d = clr ? '0 : d_in;
                end
            end
            MASTER: begin
                if (cnt_q == HOLD_T) begin
                    state_d = GAP;
                    cnt_d   = '0;
                end
            end
            GAP: begin
                if (cnt_q == DEAD_T) begin
                    state_d = SLAVE;
                    cnt_d   = '0;
                end
            end
            SLAVE: begin
                if (cnt_q == HOLD_T) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs decode the next state so they are registered yet aligned with it.
        m_en_d = (state_d == MASTER);
        s_en_d = (state_d == SLAVE);
        busy_d = (state_d != IDLE);
        ack_d  = (state_d == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            lat_d_q <= '0;
            m_en_q  <= 1'b0;
            s_en_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            lat_d_q <= lat_d_d;
            m_en_q  <= m_en_d;
            s_en_q  <= s_en_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign lat_d = lat_d_q;
    assign m_en  = m_en_q;
    assign s_en  = s_en_q;
    assign busy  = busy_q;
    assign ack   = ack_q;

endmodule

// File: tb/tb_ms_latch_seq.sv
// Scoreboard bench for ms_latch_seq: two builds (HOLD=2/DEAD=1, HOLD=1/DEAD=3)
// checked every cycle against a timing model keyed on each accept cycle.
module tb_ms_latch_seq;

    localparam int H0 = 2;
    localparam int D0 = 1;
    localparam int H1 = 1;
    localparam int D1 = 3;

    typedef struct {
        logic [7:0] data;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req_a   [2];
    logic       clr_a   [2];
    logic [7:0] d_in_a  [2];
    logic [7:0] lat_d_a [2];
    logic       m_en_a  [2];
    logic       s_en_a  [2];
    logic       busy_a  [2];
    logic       ack_a   [2];

    exp_t       q [2][$];
    logic [7:0] last [2];
    int         cyc = 0;
    int         vectors = 0;
    int         miscompares = 0;
    logic       armed = 1'b0;
    logic       chk_end = 1'b0;

    ms_latch_seq #(.WIDTH(8), .HOLD(H0), .DEAD(D0)) u_dut0 (
        .clk  (clk),
        .rst  (rst),
        .req  (req_a[0]),
        .clr  (clr_a[0]),
        .d_in (d_in_a[0]),
        .lat_d(lat_d_a[0]),
        .m_en (m_en_a[0]),
        .s_en (s_en_a[0]),
        .busy (busy_a[0]),
        .ack  (ack_a[0])
    );

    ms_latch_seq #(.WIDTH(8), .HOLD(H1), .DEAD(D1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .req  (req_a[1]),
        .clr  (clr_a[1]),
        .d_in (d_in_a[1]),
        .lat_d(lat_d_a[1]),
        .m_en (m_en_a[1]),
        .s_en (s_en_a[1]),
        .busy (busy_a[1]),
        .ack  (ack_a[1])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: expected outputs derived from the queued accept cycle.
    always @(negedge clk) begin
        int          h;
        int          d;
        int          rel;
        logic [11:0] ev;
        logic [11:0] av;
        logic        popit;
        exp_t        e;
        if (chk_end) begin
            for (int k = 0; k < 2; k++) begin
                vectors++;
                if (q[k].size() != 0) begin
                    miscompares++;
                    $display("FAIL pending_inst%0d: got %0d left, want 0",
                             k, q[k].size());
                end
            end
        end else if (armed) begin
            for (int k = 0; k < 2; k++) begin
                h = (k == 0) ? H0 : H1;
                d = (k == 0) ? D0 : D1;
                av = {busy_a[k], m_en_a[k], s_en_a[k], ack_a[k],
                      lat_d_a[k]};
                ev = {4'b0000, last[k]};
                popit = 1'b0;
                e = '{data: 8'h00, acc: 0};
                if (q[k].size() > 0) begin
                    e = q[k][0];
                    rel = cyc - e.acc;
                    if (rel >= 1) begin
                        ev = {1'b1, (rel <= h),
                              (rel >= h + d + 1 && rel <= 2 * h + d),
                              (rel == 2 * h + d + 1), e.data};
                        popit = (rel >= 2 * h + d + 1);
                    end
                end
                vectors++;
                if (av !== ev) begin
                    miscompares++;
                    $display("FAIL outs_inst%0d cyc %0d {busy,m,s,ack,lat}: got %h want %h",
                             k, cyc, av, ev);
                end
                vectors++;
                if ((m_en_a[k] & s_en_a[k]) !== 1'b0) begin
                    miscompares++;
                    $display("FAIL mutex_inst%0d cyc %0d: got m=%b s=%b want not both",
                             k, cyc, m_en_a[k], s_en_a[k]);
                end
                if (popit) begin
                    void'(q[k].pop_front());
                    last[k] = e.data;
                end
            end
        end
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                q[k].delete();
                last[k] = 8'h00;
            end
            armed = 1'b1;
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int k, input logic r, input logic c,
                         input logic [7:0] dv);
        req_a[k] = r;
        clr_a[k] = c;
        d_in_a[k] = dv;
        q[k].push_back('{data: (c ? 8'h00 : dv), acc: cyc});
    endtask

    initial begin
        int a;
        for (int k = 0; k < 2; k++) begin
            req_a[k] = 1'b0;
            clr_a[k] = 1'b0;
            d_in_a[k] = 8'h00;
            last[k] = 8'h00;
        end
        repeat (2) next_cyc();
        rst = 1'b0;
        repeat (2) next_cyc();

        issue(0, 1'b1, 1'b0, 8'hA5);
        next_cyc();
        req_a[0] = 1'b0;
        repeat (8) next_cyc();

        issue(0, 1'b1, 1'b1, 8'hFF);
        a = cyc;
        next_cyc();
        req_a[0] = 1'b0;
        clr_a[0] = 1'b0;
        while (cyc < a + 3) next_cyc();
        req_a[0] = 1'b1;
        d_in_a[0] = 8'h77;
        next_cyc();
        req_a[0] = 1'b0;
        repeat (8) next_cyc();

        issue(0, 1'b1, 1'b0, 8'h3C);
        a = cyc;
        next_cyc();
        req_a[0] = 1'b0;
        while (cyc < a + 4) next_cyc();
        rst = 1'b1;
        next_cyc();
        rst = 1'b0;
        repeat (3) next_cyc();
        issue(0, 1'b1, 1'b0, 8'h5A);
        next_cyc();
        req_a[0] = 1'b0;
        repeat (8) next_cyc();

        for (int i = 1; i <= 3; i++) begin
            issue(0, 1'b1, 1'b0, 8'(i));
            if (i < 3) repeat (2 * H0 + D0 + 2) next_cyc();
        end
        next_cyc();
        req_a[0] = 1'b0;
        repeat (9) next_cyc();

        issue(1, 1'b1, 1'b0, 8'hC3);
        next_cyc();
        req_a[1] = 1'b0;
        repeat (9) next_cyc();
        issue(1, 1'b0, 1'b1, 8'h99);
        next_cyc();
        clr_a[1] = 1'b0;
        repeat (9) next_cyc();

        chk_end = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
